data_mem_io: RTL and testbench
==============================

DATA_MEM_IO -- requirements
Module: data_mem_io

Interface
REQ-001 Parameter RAM_AW, default 8, RAM address width; RAM depth is 2**RAM_AW 16-bit words.
REQ-002 Parameter SYNC_STAGES, default 2, number of flops in the sw_in synchronizer (minimum 2).
REQ-003 ck  input  1  clock; all state updates on posedge ck.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 da  input  16  data address from the CPU data port.
REQ-006 dd  inout  16  bidirectional data bus; driven by this block only when rw==1, otherwise high-Z.
REQ-007 rw  input  1  1 = read (block drives dd), 0 = write (CPU drives dd).
REQ-008 sw_in  input  8  asynchronous switch inputs.
REQ-009 led_out  output  8  registered output port.
REQ-010 irq_tmr  output  1  copy of the timer expired flag TSTAT[0].

Function
REQ-011 Address map: 0x0000 to 2**RAM_AW-1 = RAM; 0xFF00 LED (R/W, bits 7:0); 0xFF01 SW (RO, synchronized sw_in, upper bits 0); 0xFF02 TCTL (R/W, bit0 EN, bit1 RELOAD); 0xFF03 TLOAD (R/W); 0xFF04 TCNT (RO); 0xFF05 TSTAT (bit0 EXP; write 1 to clear).
REQ-012 All other addresses: reads return 0x0000; writes are ignored.
REQ-013 Read path is combinational from da: dd = selected word within the same cycle da changes; no read side effects.
REQ-014 Write commits on the first posedge at which rw==0 is sampled after a posedge with rw==1 (rw_q held in a flop); further cycles with rw held low do not re-commit.
REQ-015 Write data and address are taken from dd and da sampled at the committing edge.
REQ-016 Writes to RO registers (SW, TCNT) are ignored; unused register bits read as 0 and ignore writes.
REQ-017 Writing TLOAD also loads TCNT with the written value on the same edge.
REQ-018 Timer, per edge with EN==1 and no TLOAD write: TCNT!=0 -> TCNT-1; TCNT==0 -> EXP<=1 and (RELOAD==1 ? TCNT<=TLOAD : EN<=0, TCNT stays 0).
REQ-019 EN==0: TCNT holds.
REQ-020 Simultaneous expiry and TSTAT write-1-clear: set wins, EXP stays 1.
REQ-021 Simultaneous expiry and TCTL write: the written TCTL value wins over the auto-clear of EN; EXP is still set.
REQ-022 Writing TSTAT with bit0 = 0 leaves EXP unchanged.
REQ-023 SW register = output of the SYNC_STAGES flop chain; sw_in change visible at 0xFF01 SYNC_STAGES edges later.
REQ-024 irq_tmr is driven directly by the EXP flop; it is not gated by EN.
REQ-025 RAM contents are not initialized and not affected by rst; reads of never-written RAM words are undefined (X allowed in simulation).

Reset
REQ-026 While rst==1 at an edge: led_out=0x00, TCTL=0, TLOAD=0, TCNT=0, EXP=0, irq_tmr=0, synchronizer flops=0, and rw_q=1.
REQ-027 A write pending (rw==0) at the edge rst is asserted is discarded; after rst falls, a write commits only after rw is first sampled high.
REQ-028 dd tristate control depends only on rw and is not gated by rst.

Verification
REQ-029 rw=0, da=0x0012, dd=0xBEEF for one edge, then rw=1 -> dd reads 0xBEEF combinationally at da=0x0012; da=0x0112 reads 0x0000.
REQ-030 rw held 0 for 3 edges at da=0xFF00; dd changes from 0x00A5 to 0x005A after the first edge -> led_out=0xA5 stays.
REQ-031 Write TLOAD=3, TCTL=0x1 -> TCNT reads 3,2,1,0 on successive edges, EXP=1 and irq_tmr=1 the next edge, EN reads 0.
REQ-032 TLOAD=2, TCTL=0x3 -> TCNT sequence 2,1,0,2,1,0 with EXP set at each expiry; TSTAT write 0x0001 at an expiry edge -> EXP remains 1.
REQ-033 sw_in changed 0x00->0x3C -> 0xFF01 reads 0x003C exactly SYNC_STAGES edges later; rw=0 -> dd is high-Z.
REQ-034 Assert rst mid-countdown with led_out=0xFF -> led_out=0x00, TCNT=0, EXP=0, previously written RAM word retains value.

Source files
------------

// File: rtl/data_mem_io.sv
// CPU data-port decoder: word RAM plus memory-mapped LED, switch, and down-counting timer registers.
// Reads are combinational from da onto the tristate dd bus; writes commit on the rw high-to-low edge.
module data_mem_io #(
    parameter int unsigned RAM_AW      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        ck,
    input  logic        rst,
    input  logic [15:0] da,
    inout  wire  [15:0] dd,
    input  logic        rw,
    input  logic [7:0]  sw_in,
    output logic [7:0]  led_out,
    output logic        irq_tmr
);

    localparam int unsigned RAM_DEPTH = 1 << RAM_AW;

    localparam logic [15:0] ADDR_LED   = 16'hFF00;
    localparam logic [15:0] ADDR_SW    = 16'hFF01;
    localparam logic [15:0] ADDR_TCTL  = 16'hFF02;
    localparam logic [15:0] ADDR_TLOAD = 16'hFF03;
    localparam logic [15:0] ADDR_TCNT  = 16'hFF04;
    localparam logic [15:0] ADDR_TSTAT = 16'hFF05;

    logic [15:0] mem [RAM_DEPTH];

    logic                        rw_q;
    logic [7:0]                  led_q;
    logic [1:0]                  tctl_q;
    logic [15:0]                 tload_q;
    logic [15:0]                 tcnt_q;
    logic                        exp_q;
    logic [SYNC_STAGES-1:0][7:0] sync_q;

    logic        ram_sel;
    logic        commit;
    logic        wr_led;
    logic        wr_tctl;
    logic        wr_tload;
    logic        wr_tstat;
    logic        expire;
    logic [15:0] rdata;

    // RAM occupies every address whose bits above RAM_AW are zero
    assign ram_sel  = (da >> RAM_AW) == 16'd0;
    assign commit   = rw_q && !rw && !rst;
    assign wr_led   = commit && (da == ADDR_LED);
    assign wr_tctl  = commit && (da == ADDR_TCTL);
    assign wr_tload = commit && (da == ADDR_TLOAD);
    assign wr_tstat = commit && (da == ADDR_TSTAT);
    assign expire   = tctl_q[0] && (tcnt_q == 16'd0) && !wr_tload;

    // Combinational read mux; unmapped addresses return zero
    always_comb begin
        rdata = 16'h0000;
        if (ram_sel) begin
            rdata = mem[da[RAM_AW-1:0]];
        end else begin
            case (da)
                ADDR_LED:   rdata = {8'h00, led_q};
                ADDR_SW:    rdata = {8'h00, sync_q[SYNC_STAGES-1]};
                ADDR_TCTL:  rdata = {14'h0000, tctl_q};
                ADDR_TLOAD: rdata = tload_q;
                ADDR_TCNT:  rdata = tcnt_q;
                ADDR_TSTAT: rdata = {15'h0000, exp_q};
                default:    rdata = 16'h0000;
            endcase
        end
    end

    assign dd = rw ? rdata : 16'hzzzz;

    // RAM is deliberately outside reset
    always_ff @(posedge ck) begin
        if (commit && ram_sel) begin
            mem[da[RAM_AW-1:0]] <= dd;
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw_in};
        end
    end

    // Register file and timer; an explicit TCTL or TSTAT write arbitrates against expiry
    always_ff @(posedge ck) begin
        if (rst) begin
            rw_q    <= 1'b1;
            led_q   <= 8'h00;
            tctl_q  <= 2'b00;
            tload_q <= 16'h0000;
            tcnt_q  <= 16'h0000;
            exp_q   <= 1'b0;
        end else begin
            rw_q <= rw;

            if (wr_led) begin
                led_q <= dd[7:0];
            end

            if (wr_tctl) begin
                tctl_q <= dd[1:0];
            end else if (expire && !tctl_q[1]) begin
                tctl_q[0] <= 1'b0;
            end

            if (wr_tload) begin
                tload_q <= dd;
                tcnt_q  <= dd;
            end else if (tctl_q[0]) begin
                if (tcnt_q != 16'd0) begin
                    tcnt_q <= tcnt_q - 16'd1;
                end else if (tctl_q[1]) begin
                    tcnt_q <= tload_q;
                end
            end

            if (expire) begin
                exp_q <= 1'b1;
            end else if (wr_tstat && dd[0]) begin
                exp_q <= 1'b0;
            end
        end
    end

    assign led_out = led_q;
    assign irq_tmr = exp_q;

endmodule

// File: tb/tb_data_mem_io.sv
// Directed bench for data_mem_io: vector table for the register map, hand sequences for
// write-commit, timer, synchronizer, tristate and reset corner cases.
module tb_data_mem_io;

    logic        ck = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] da = 16'h0000;
    logic        rw = 1'b1;
    logic [15:0] dd_drv = 16'h0000;
    logic [7:0]  sw_in = 8'h00;
    logic [7:0]  led_out;
    logic        irq_tmr;
    wire  [15:0] dd;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
    } vec_t;

    vec_t tbl[$];

    assign dd = rw ? 16'hzzzz : dd_drv;

    data_mem_io #(.RAM_AW(8), .SYNC_STAGES(2)) dut (
        .ck(ck), .rst(rst), .da(da), .dd(dd), .rw(rw),
        .sw_in(sw_in), .led_out(led_out), .irq_tmr(irq_tmr)
    );

    initial forever #5 ck = ~ck;

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd(input string name, input logic [15:0] addr, input logic [15:0] exp);
        rw = 1'b1;
        da = addr;
        #1;
        check(name, dd, exp);
    endtask

    // One committing edge with rw low, then one edge with rw high
    task automatic wr_reg(input logic [15:0] addr, input logic [15:0] data);
        da = addr;
        dd_drv = data;
        rw = 1'b0;
        tick();
        rw = 1'b1;
        tick();
    endtask

    initial begin
        tbl.push_back('{1'b0, 16'hFF00, 16'h0000});
        tbl.push_back('{1'b0, 16'hFF02, 16'h0000});
        tbl.push_back('{1'b0, 16'hFF03, 16'h0000});
        tbl.push_back('{1'b0, 16'hFF04, 16'h0000});
        tbl.push_back('{1'b0, 16'hFF05, 16'h0000});
        tbl.push_back('{1'b1, 16'h0012, 16'hBEEF});
        tbl.push_back('{1'b0, 16'h0012, 16'hBEEF});
        tbl.push_back('{1'b0, 16'h0112, 16'h0000});
        tbl.push_back('{1'b1, 16'h00FF, 16'h1234});
        tbl.push_back('{1'b1, 16'h0000, 16'hA5A5});
        tbl.push_back('{1'b0, 16'h00FF, 16'h1234});
        tbl.push_back('{1'b0, 16'h0000, 16'hA5A5});
        tbl.push_back('{1'b1, 16'hFF00, 16'h12C3});
        tbl.push_back('{1'b0, 16'hFF00, 16'h00C3});
        tbl.push_back('{1'b1, 16'hFF02, 16'hFFFE});
        tbl.push_back('{1'b0, 16'hFF02, 16'h0002});
        tbl.push_back('{1'b1, 16'hFF03, 16'h0077});
        tbl.push_back('{1'b0, 16'hFF03, 16'h0077});
        tbl.push_back('{1'b0, 16'hFF04, 16'h0077});
        tbl.push_back('{1'b1, 16'hFF04, 16'h1111});
        tbl.push_back('{1'b0, 16'hFF04, 16'h0077});
        tbl.push_back('{1'b1, 16'hFF01, 16'h00FF});
        tbl.push_back('{1'b0, 16'hFF01, 16'h0000});
        tbl.push_back('{1'b1, 16'hFF06, 16'h5555});
        tbl.push_back('{1'b0, 16'hFF06, 16'h0000});
        tbl.push_back('{1'b0, 16'h8000, 16'h0000});
        tbl.push_back('{1'b1, 16'hFF02, 16'h0000});
        tbl.push_back('{1'b0, 16'hFF02, 16'h0000});

        tick();
        tick();
        rst = 1'b0;
        tick();
        check("reset_led_out", {8'h00, led_out}, 16'h0000);
        check("reset_irq", {15'h0000, irq_tmr}, 16'h0000);

        foreach (tbl[i]) begin
            if (tbl[i].wr) wr_reg(tbl[i].addr, tbl[i].data);
            else rd($sformatf("vec%0d_rd_%h", i, tbl[i].addr), tbl[i].addr, tbl[i].data);
        end

        // Held-low rw commits only once
        da = 16'hFF00; dd_drv = 16'h00A5; rw = 1'b0;
        tick();
        dd_drv = 16'h005A;
        tick();
        tick();
        check("hold_led_out", {8'h00, led_out}, 16'h00A5);
        rw = 1'b1;
        tick();
        check("hold_led_after", {8'h00, led_out}, 16'h00A5);
        rd("hold_led_rd", 16'hFF00, 16'h00A5);

        // Switch synchronizer latency and bus release during writes
        sw_in = 8'h3C;
        tick();
        rd("sw_edge1", 16'hFF01, 16'h0000);
        tick();
        rd("sw_edge2", 16'hFF01, 16'h003C);
        da = 16'hFF01; dd_drv = 16'h0000; rw = 1'b0;
        #1;
        check("dd_released", dd, 16'h0000);
        rw = 1'b1;
        tick();

        // One-shot countdown
        wr_reg(16'hFF03, 16'h0003);
        da = 16'hFF02; dd_drv = 16'h0001; rw = 1'b0;
        tick();
        rd("os_tcnt3", 16'hFF04, 16'h0003);
        rd("os_en_on", 16'hFF02, 16'h0001);
        tick();
        rd("os_tcnt2", 16'hFF04, 16'h0002);
        tick();
        rd("os_tcnt1", 16'hFF04, 16'h0001);
        tick();
        rd("os_tcnt0", 16'hFF04, 16'h0000);
        check("os_irq_pre", {15'h0000, irq_tmr}, 16'h0000);
        tick();
        check("os_irq", {15'h0000, irq_tmr}, 16'h0001);
        rd("os_exp", 16'hFF05, 16'h0001);
        rd("os_en_off", 16'hFF02, 16'h0000);
        tick();
        rd("os_tcnt_hold", 16'hFF04, 16'h0000);
        wr_reg(16'hFF05, 16'h0000);
        rd("tstat_wr0_keeps", 16'hFF05, 16'h0001);
        wr_reg(16'hFF05, 16'h0001);
        rd("tstat_wr1_clears", 16'hFF05, 16'h0000);
        check("irq_cleared", {15'h0000, irq_tmr}, 16'h0000);

        wr_reg(16'hFF00, 16'h00FF);
        check("led_ff", {8'h00, led_out}, 16'h00FF);

        // Auto-reload countdown with clear against expiry
        wr_reg(16'hFF03, 16'h0002);
        da = 16'hFF02; dd_drv = 16'h0003; rw = 1'b0;
        tick();
        rw = 1'b1;
        rd("rl_tcnt2a", 16'hFF04, 16'h0002);
        tick();
        rd("rl_tcnt1a", 16'hFF04, 16'h0001);
        tick();
        rd("rl_tcnt0a", 16'hFF04, 16'h0000);
        tick();
        rd("rl_tcnt2b", 16'hFF04, 16'h0002);
        rd("rl_exp_a", 16'hFF05, 16'h0001);
        da = 16'hFF05; dd_drv = 16'h0001; rw = 1'b0;
        tick();
        rw = 1'b1;
        rd("rl_tcnt1b", 16'hFF04, 16'h0001);
        rd("rl_exp_cleared", 16'hFF05, 16'h0000);
        tick();
        rd("rl_tcnt0b", 16'hFF04, 16'h0000);
        da = 16'hFF05; dd_drv = 16'h0001; rw = 1'b0;
        tick();
        rw = 1'b1;
        rd("rl_set_wins", 16'hFF05, 16'h0001);
        rd("rl_tcnt2c", 16'hFF04, 16'h0002);
        rd("rl_en_kept", 16'hFF02, 16'h0003);
        tick();
        rd("rl_tcnt1c", 16'hFF04, 16'h0001);

        // Reset mid-countdown with a RAM write pending on the reset edge
        da = 16'h0012; dd_drv = 16'h5555; rw = 1'b0; rst = 1'b1;
        tick();
        check("rst_led_out", {8'h00, led_out}, 16'h00FF & 16'h0000);
        check("rst_irq", {15'h0000, irq_tmr}, 16'h0000);
        rw = 1'b1;
        rst = 1'b0;
        tick();
        rd("rst_tcnt", 16'hFF04, 16'h0000);
        rd("rst_exp", 16'hFF05, 16'h0000);
        rd("rst_tctl", 16'hFF02, 16'h0000);
        rd("rst_tload", 16'hFF03, 16'h0000);
        rd("rst_ram_kept", 16'h0012, 16'hBEEF);
        rd("rst_sw", 16'hFF01, 16'h0000);
        tick();
        rd("rst_sw_resync", 16'hFF01, 16'h003C);
        rd("rst_tcnt_hold", 16'hFF04, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
